// File: rtl/pll_sequencer_pkg.sv
// rtl/pll_sequencer_pkg.sv - state encoding and counter widths for the PLL start-up sequencer
package pll_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    // Shared by the PLL reset pulse counter and the o_rst hold counter.
    localparam int AR_W     = 8;
    localparam int STABLE_W = 10;
    localparam int WAIT_W   = 16;
    localparam int RETRY_W  = 4;

endpackage

// File: rtl/pll_sequencer_sync.sv
// rtl/pll_sequencer_sync.sv - 2-flop synchronizer with asynchronous active-low clear
//
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low clear of both flops
//   d      asynchronous input
//   q      synchronized output, two clk cycles behind d
module pll_sequencer_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_sequencer.sv
// rtl/pll_sequencer.sv - PLL reset / lock-wait / system-reset release sequencer
//
// Optional feature macro: PLL_SEQUENCER_RELOCK_EN
//   defined   : loss of lock in RUN re-pulses the PLL reset
//   undefined : loss of lock in RUN only returns to waiting for lock
//
// Ports:
//   i_clk         free-running reference clock (not the PLL output)
//   i_rst_n       asynchronous active-low reset
//   i_locked      PLL lock indication, asynchronous to i_clk
//   i_restart     one-cycle request to leave FAIL; ignored elsewhere
//   o_pll_areset  active-high reset to the PLL
//   o_rst         active-high reset for logic clocked by the PLL output
//   o_ready       high only in RUN
//   o_fail        high only in FAIL
//   o_retries     lock timeouts since the last fresh start, saturating at 15
module pll_sequencer
    import pll_sequencer_pkg::*;
#(
    parameter int AR_CYCLES   = 16,
    parameter int LOCK_STABLE = 64,
    parameter int TIMEOUT     = 4096,
    parameter int RST_HOLD    = 10,
    parameter int MAX_RETRIES = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_locked,
    input  logic               i_restart,
    output logic               o_pll_areset,
    output logic               o_rst,
    output logic               o_ready,
    output logic               o_fail,
    output logic [RETRY_W-1:0] o_retries
);

    // Terminal counts: each counter holds the number of cycles already
    // completed, so the transition fires in the cycle that completes the count.
    localparam logic [AR_W-1:0]     AR_LAST     = AR_W'(AR_CYCLES - 1);
    localparam logic [AR_W-1:0]     HOLD_LAST   = AR_W'(RST_HOLD - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE - 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(TIMEOUT - 1);
    localparam logic [RETRY_W:0]    RETRY_LIMIT = (RETRY_W + 1)'(MAX_RETRIES);

    state_t               state, state_n;
    logic [AR_W-1:0]      cnt, cnt_n;
    logic [STABLE_W-1:0]  stable, stable_n;
    logic [WAIT_W-1:0]    wait_cnt, wait_n;
    logic [RETRY_W-1:0]   retries_n;
    logic [RETRY_W:0]     retry_next;
    logic                 lock_s;

    pll_sequencer_sync u_lock_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_locked),
        .q     (lock_s)
    );

    // One extra bit so the fail decision sees the unsaturated count.
    assign retry_next = {1'b0, o_retries} + 1'b1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        stable_n  = stable;
        wait_n    = wait_cnt;
        retries_n = o_retries;

        case (state)
            ST_RESET_PLL: begin
                if (cnt == AR_LAST) begin
                    state_n  = ST_WAIT_LOCK;
                    stable_n = '0;
                    wait_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_WAIT_LOCK: begin
                stable_n = lock_s ? stable + 1'b1 : '0;
                wait_n   = wait_cnt + 1'b1;
                // Acceptance is tested first so it wins a tie with the timeout.
                if (lock_s && (stable == STABLE_LAST)) begin
                    state_n = ST_RELEASE;
                    cnt_n   = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    retries_n = retry_next[RETRY_W] ? '1 : retry_next[RETRY_W-1:0];
                    cnt_n     = '0;
                    state_n   = (retry_next > RETRY_LIMIT) ? ST_FAIL : ST_RESET_PLL;
                end
            end

            ST_RELEASE: begin
                if (!lock_s) begin
                    state_n  = ST_WAIT_LOCK;
                    stable_n = '0;
                    wait_n   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_n   = ST_RUN;
                    retries_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            ST_RUN: begin
                if (!lock_s) begin
`ifdef PLL_SEQUENCER_RELOCK_EN
                    state_n   = ST_RESET_PLL;
                    cnt_n     = '0;
                    retries_n = '0;
`else
                    state_n  = ST_WAIT_LOCK;
                    stable_n = '0;
                    wait_n   = '0;
`endif
                end
            end

            ST_FAIL: begin
                if (i_restart) begin
                    state_n   = ST_RESET_PLL;
                    cnt_n     = '0;
                    retries_n = '0;
                end
            end

            default: begin
                state_n = ST_RESET_PLL;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they change
    // on the same edge as the state and never see an input combinationally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_RESET_PLL;
            cnt          <= '0;
            stable       <= '0;
            wait_cnt     <= '0;
            o_retries    <= '0;
            o_pll_areset <= 1'b1;
            o_rst        <= 1'b1;
            o_ready      <= 1'b0;
            o_fail       <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            stable       <= stable_n;
            wait_cnt     <= wait_n;
            o_retries    <= retries_n;
            o_pll_areset <= (state_n == ST_RESET_PLL);
            o_rst        <= (state_n != ST_RUN);
            o_ready      <= (state_n == ST_RUN);
            o_fail       <= (state_n == ST_FAIL);
        end
    end

endmodule
